// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues predictor npc to instruction memory, tracks in-order
// outstanding requests in a circular buffer and hands {pc, inst} pairs to DECODE.
module fetch_stage #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] npc,
   input  logic        br_late_done,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        dec_valid,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_inst,
   input  logic        dec_ready,
   output logic        fetch_stall,
   output logic [31:0] inst_feedback
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   logic [31:0]      pc_p0   [DEPTH];
   logic [31:0]      inst_p0 [DEPTH];
   logic [DEPTH-1:0] filled_p0;
   logic [PW-1:0]    alloc_p0;
   logic [PW-1:0]    fill_p0;
   logic [PW-1:0]    head_p0;
   logic [CW-1:0]    occ_p0;
   logic [CW-1:0]    drop_p0;
   logic [CW-1:0]    pend_p0;
   logic             rst_released_p0;

   logic             grant;
   logic             resp;
   logic             take;
   logic             pop;
   logic [CW:0]      inflight;
   logic [CW:0]      squash;
   logic [PW-1:0]    wr_idx;

   // pend_p0 counts allocated-but-unfilled entries; squashed work moves into drop on a flush
   assign inflight    = {1'b0, occ_p0} + {1'b0, drop_p0};
   assign imem_req    = rst_released_p0 & (inflight < DEPTH_C);
   assign grant       = imem_req & imem_gnt;
   assign fetch_stall = ~grant;
   assign imem_addr   = npc;

   assign resp   = rst_released_p0 & imem_rvalid;
   assign take   = resp & (drop_p0 == '0) & ~br_late_done;
   assign squash = {1'b0, drop_p0} + {1'b0, pend_p0} - {{CW{1'b0}}, resp};
   assign wr_idx = br_late_done ? '0 : alloc_p0;

   assign dec_valid     = (occ_p0 != '0) & filled_p0[head_p0];
   assign pop           = dec_valid & dec_ready & ~br_late_done;
   assign dec_pc        = dec_valid ? pc_p0[head_p0] : '0;
   assign dec_inst      = dec_valid ? inst_p0[head_p0] : NOP_WORD;
   assign inst_feedback = dec_inst;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_released_p0 <= 1'b0;
         alloc_p0        <= '0;
         fill_p0         <= '0;
         head_p0         <= '0;
         occ_p0          <= '0;
         drop_p0         <= '0;
         pend_p0         <= '0;
         filled_p0       <= '0;
      end else begin
         rst_released_p0 <= 1'b1;
         if (br_late_done) begin
            // a grant in the flush cycle is the redirect fetch and lands in entry 0
            head_p0   <= '0;
            fill_p0   <= '0;
            alloc_p0  <= grant ? PW'(1) : '0;
            occ_p0    <= grant ? CW'(1) : '0;
            pend_p0   <= grant ? CW'(1) : '0;
            drop_p0   <= squash[CW-1:0];
            filled_p0 <= '0;
         end else begin
            if (grant) begin
               alloc_p0            <= alloc_p0 + PW'(1);
               filled_p0[alloc_p0] <= 1'b0;
            end
            if (take) begin
               fill_p0            <= fill_p0 + PW'(1);
               filled_p0[fill_p0] <= 1'b1;
            end
            if (pop) head_p0 <= head_p0 + PW'(1);
            if (resp && (drop_p0 != '0)) drop_p0 <= drop_p0 - CW'(1);
            occ_p0  <= occ_p0 + CW'(grant) - CW'(pop);
            pend_p0 <= pend_p0 + CW'(grant) - CW'(take);
         end
      end
   end

   // buffer payload carries no reset; dec_* outputs are gated by dec_valid
   always_ff @(posedge clk) begin
      if (grant) pc_p0[wr_idx]    <= npc;
      if (take)  inst_p0[fill_p0] <= imem_rdata;
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_fetch_stage;

   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic [31:0] npc;
   logic        br_late_done;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        dec_valid;
   logic [31:0] dec_pc;
   logic [31:0] dec_inst;
   logic        dec_ready;
   logic        fetch_stall;
   logic [31:0] inst_feedback;

   fetch_stage #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst(rst), .npc(npc), .br_late_done(br_late_done),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_ready(dec_ready),
      .fetch_stall(fetch_stall), .inst_feedback(inst_feedback)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   typedef struct {
      logic [31:0] npc;
      bit          gnt, rv, rdy, br;
      bit          e_req, e_stall, e_dv;
      logic [31:0] e_pc, e_inst;
   } vec_t;

   int          tests = 0;
   int          fails = 0;
   bit          released_m;
   int          drop_m;
   logic [31:0] pend_m[$];
   ent_t        ready_m[$];
   logic [31:0] mem_q[$];

   logic        s_req, s_stall, s_dv;
   logic [31:0] s_pc, s_inst;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got no delivery expected one within bound at %0t", name, $time);
   endtask

   // Called just after a rising edge; leaves just after the next rising edge.
   task automatic step(input logic [31:0] n, input bit g, input bit rv, input bit rdy, input bit br,
                       output logic o_req, output logic o_stall, output logic o_dv,
                       output logic [31:0] o_pc, output logic [31:0] o_inst);
      bit          rv_eff, exp_req, exp_grant, exp_dv;
      logic [31:0] exp_inst;
      int          total;
      ent_t        e;
      rv_eff       = rv && (mem_q.size() > 0);
      npc          = n;
      imem_gnt     = g;
      imem_rvalid  = rv_eff;
      imem_rdata   = rv_eff ? inst_of(mem_q[0]) : $urandom;
      dec_ready    = rdy;
      br_late_done = br;
      @(negedge clk);
      exp_req   = released_m && ((pend_m.size() + ready_m.size() + drop_m) < DEPTH);
      exp_grant = exp_req && g;
      exp_dv    = ready_m.size() > 0;
      exp_inst  = exp_dv ? ready_m[0].inst : NOP;
      o_req = imem_req; o_stall = fetch_stall; o_dv = dec_valid; o_pc = dec_pc; o_inst = dec_inst;
      check("req", imem_req, exp_req);
      check("stall", fetch_stall, !exp_grant);
      check("addr", imem_addr, n);
      check("dvalid", dec_valid, exp_dv);
      if (exp_dv) check("dpc", dec_pc, ready_m[0].pc);
      check("dinst", dec_inst, exp_inst);
      check("feedback", inst_feedback, exp_inst);
      @(posedge clk);
      if (rv_eff) void'(mem_q.pop_front());
      if (exp_grant) mem_q.push_back(n);
      if (br) begin
         total = drop_m + pend_m.size();
         if (rv_eff && total > 0) total--;
         drop_m = total;
         pend_m.delete();
         ready_m.delete();
      end else begin
         if (exp_dv && rdy) void'(ready_m.pop_front());
         if (rv_eff) begin
            if (drop_m > 0) drop_m--;
            else if (pend_m.size() > 0) begin
               e.pc   = pend_m.pop_front();
               e.inst = inst_of(e.pc);
               ready_m.push_back(e);
            end
         end
      end
      if (exp_grant) pend_m.push_back(n);
      released_m = 1'b1;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check("rst_dvalid", dec_valid, 1'b0);
      check("rst_dinst", dec_inst, NOP);
      check("rst_fb", inst_feedback, NOP);
      check("rst_dpc", dec_pc, 32'h0);
      check("rst_req", imem_req, 1'b0);
      check("rst_stall", fetch_stall, 1'b1);
      released_m = 1'b0;
      drop_m     = 0;
      pend_m.delete();
      ready_m.delete();
      mem_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        tbl[8];
      logic [31:0] pc_n;
      logic [31:0] exp_next;
      bit          got;
      bit          g, rv, rdy, br;

      rst = 1'b0; npc = '0; br_late_done = 1'b0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0; dec_ready = 1'b0;

      tbl[0] = '{32'h0, 1, 0, 1, 0, 0, 1, 0, 32'h0, NOP};
      tbl[1] = '{32'h0, 1, 0, 1, 0, 1, 0, 0, 32'h0, NOP};
      tbl[2] = '{32'h4, 1, 1, 1, 0, 1, 0, 0, 32'h0, NOP};
      tbl[3] = '{32'h8, 1, 1, 1, 0, 0, 1, 1, 32'h0, inst_of(32'h0)};
      tbl[4] = '{32'h8, 1, 0, 1, 0, 1, 0, 1, 32'h4, inst_of(32'h4)};
      tbl[5] = '{32'hC, 1, 1, 1, 0, 1, 0, 0, 32'h0, NOP};
      tbl[6] = '{32'h10, 1, 1, 1, 0, 0, 1, 1, 32'h8, inst_of(32'h8)};
      tbl[7] = '{32'h10, 1, 0, 1, 0, 1, 0, 1, 32'hC, inst_of(32'hC)};

      @(posedge clk);
      #1;
      do_reset();

      // vector table: reset release then 1-cycle memory stream
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].npc, tbl[i].gnt, tbl[i].rv, tbl[i].rdy, tbl[i].br, s_req, s_stall, s_dv, s_pc, s_inst);
         check($sformatf("tbl%0d_req", i), s_req, tbl[i].e_req);
         check($sformatf("tbl%0d_stall", i), s_stall, tbl[i].e_stall);
         check($sformatf("tbl%0d_dv", i), s_dv, tbl[i].e_dv);
         if (tbl[i].e_dv) check($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
         check($sformatf("tbl%0d_inst", i), s_inst, tbl[i].e_inst);
      end

      // back-pressure: buffer fills, then one grant per pop in order
      do_reset();
      step(32'h1000, 1, 1, 0, 0, s_req, s_stall, s_dv, s_pc, s_inst);
      pc_n = 32'h1000;
      for (int i = 0; i < 5; i++) begin
         step(pc_n, 1, 1, 0, 0, s_req, s_stall, s_dv, s_pc, s_inst);
         if (!s_stall) pc_n += 4;
      end
      check("bp_req", s_req, 1'b0);
      check("bp_stall", s_stall, 1'b1);
      check("bp_dv", s_dv, 1'b1);
      check("bp_pc", s_pc, 32'h1000);
      exp_next = 32'h1000;
      for (int i = 0; i < 10; i++) begin
         step(pc_n, 1, 1, 1, 0, s_req, s_stall, s_dv, s_pc, s_inst);
         if (!s_stall) pc_n += 4;
         if (s_dv) begin
            check("bp_order", s_pc, exp_next);
            exp_next += 4;
         end
      end

      // flush with two granted, unfilled requests; redirect to 0x100
      do_reset();
      step(32'h40, 1, 0, 1, 0, s_req, s_stall, s_dv, s_pc, s_inst);
      step(32'h40, 1, 0, 1, 0, s_req, s_stall, s_dv, s_pc, s_inst);
      step(32'h44, 1, 0, 1, 0, s_req, s_stall, s_dv, s_pc, s_inst);
      step(32'h100, 1, 0, 1, 1, s_req, s_stall, s_dv, s_pc, s_inst);
      pc_n = s_stall ? 32'h100 : 32'h104;
      got  = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         step(pc_n, 1, 1, 1, 0, s_req, s_stall, s_dv, s_pc, s_inst);
         if (!s_stall) pc_n += 4;
         if (s_dv) begin
            got = 1'b1;
            check("flush_pc", s_pc, 32'h100);
            check("flush_inst", s_inst, inst_of(32'h100));
         end
      end
      if (!got) timeout_fail("flush_deliver");

      // flush coinciding with the only outstanding response
      do_reset();
      step(32'h80, 1, 0, 1, 0, s_req, s_stall, s_dv, s_pc, s_inst);
      step(32'h80, 1, 0, 1, 0, s_req, s_stall, s_dv, s_pc, s_inst);
      step(32'h200, 1, 1, 1, 1, s_req, s_stall, s_dv, s_pc, s_inst);
      check("flrv_grant", s_stall, 1'b0);
      pc_n = 32'h204;
      got  = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         step(pc_n, 1, 1, 1, 0, s_req, s_stall, s_dv, s_pc, s_inst);
         if (!s_stall) pc_n += 4;
         if (s_dv) begin
            got = 1'b1;
            check("flrv_pc", s_pc, 32'h200);
            check("flrv_inst", s_inst, inst_of(32'h200));
         end
      end
      if (!got) timeout_fail("flrv_deliver");

      // grant withheld for three cycles
      for (int i = 0; i < 3; i++) begin
         step($urandom, 0, 1, 1, 0, s_req, s_stall, s_dv, s_pc, s_inst);
         check("gntlow_stall", s_stall, 1'b1);
      end
      step(pc_n, 1, 1, 1, 0, s_req, s_stall, s_dv, s_pc, s_inst);

      // reset asserted with two valid entries
      do_reset();
      step(32'h300, 1, 0, 0, 0, s_req, s_stall, s_dv, s_pc, s_inst);
      step(32'h300, 1, 0, 0, 0, s_req, s_stall, s_dv, s_pc, s_inst);
      step(32'h304, 1, 1, 0, 0, s_req, s_stall, s_dv, s_pc, s_inst);
      step(32'h308, 1, 1, 0, 0, s_req, s_stall, s_dv, s_pc, s_inst);
      step(32'h308, 1, 0, 0, 0, s_req, s_stall, s_dv, s_pc, s_inst);
      check("prerst_dv", s_dv, 1'b1);
      do_reset();
      step(32'h500, 1, 1, 1, 0, s_req, s_stall, s_dv, s_pc, s_inst);
      check("rst_rel_wait", s_stall, 1'b1);
      step(32'h500, 1, 1, 1, 0, s_req, s_stall, s_dv, s_pc, s_inst);
      check("rst_first_grant", s_stall, 1'b0);

      // randomized traffic
      pc_n = 32'h504;
      for (int i = 0; i < 3000; i++) begin
         g   = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 9) < 6);
         rdy = ($urandom_range(0, 9) < 7);
         br  = ($urandom_range(0, 99) < 8);
         if (br) pc_n = $urandom;
         step(pc_n, g, rv, rdy, br, s_req, s_stall, s_dv, s_pc, s_inst);
         if (!s_stall) pc_n = ($urandom_range(0, 3) == 0) ? $urandom : pc_n + 4;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
